// File: rtl/tpu_job_sched.sv
// Two-requester TPU job scheduler: round-robin grant, start pulse, done/response handshake.
// Optional watchdog enabled by defining TPU_SCHED_WATCHDOG_EN.
module tpu_job_sched #(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int CNT_WIDTH      = 8
) (
    input  logic                 clk,
    input  logic                 srstn,
    input  logic                 req0_valid,
    input  logic                 req1_valid,
    output logic                 req0_ready,
    output logic                 req1_ready,
    output logic                 tpu_start,
    input  logic                 tpu_done,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic                 rsp_id,
    output logic                 rsp_err,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] job_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RUN   = 2'd2,
        RESP  = 2'd3
    } state_t;

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES out of range 2..65535");
    end

    state_t                 state_q, state_d;
    logic                   last_grant_q, last_grant_d;
    logic                   owner_q, owner_d;
    logic                   err_q, err_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   grant_s;
    logic                   accept_s;
    logic                   timeout_s;

`ifdef TPU_SCHED_WATCHDOG_EN
    localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] wdog_q, wdog_d;

    // Watchdog counts cycles spent in RUN; it is zero on the first RUN cycle.
    always_comb begin
        if (state_q == RUN) begin
            wdog_d = wdog_q + 16'd1;
        end else begin
            wdog_d = 16'd0;
        end
    end

    // Watchdog register.
    always_ff @(posedge clk) begin
        if (!srstn) begin
            wdog_q <= 16'd0;
        end else begin
            wdog_q <= wdog_d;
        end
    end

    assign timeout_s = (wdog_q == WDOG_LAST);
`else
    assign timeout_s = 1'b0;
`endif

    // Grant selection: lone requester wins, ties (and idle) favour the one not served last.
    always_comb begin
        case ({req1_valid, req0_valid})
            2'b01:   grant_s = 1'b0;
            2'b10:   grant_s = 1'b1;
            default: grant_s = ~last_grant_q;
        endcase
    end

    assign accept_s = (req0_valid && req0_ready) || (req1_valid && req1_ready);

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (!srstn) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            err_q        <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            err_q        <= err_d;
            cnt_q        <= cnt_d;
        end
    end

    // Next-state logic; done takes priority over a same-cycle watchdog expiry.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        err_d        = err_q;
        cnt_d        = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    state_d      = START;
                    owner_d      = grant_s;
                    last_grant_d = grant_s;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                state_d = RUN;
            end
            RUN: begin
                if (tpu_done) begin
                    state_d = RESP;
                    err_d   = 1'b0;
                end else if (timeout_s) begin
                    state_d = RESP;
                    err_d   = 1'b1;
                end else begin
                    state_d = RUN;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                    cnt_d   = cnt_q + CNT_WIDTH'(1);
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decoded from the registered state.
    always_comb begin
        req0_ready = (state_q == IDLE) && (grant_s == 1'b0);
        req1_ready = (state_q == IDLE) && (grant_s == 1'b1);
        tpu_start  = (state_q == START);
        rsp_valid  = (state_q == RESP);
        rsp_id     = owner_q;
        rsp_err    = err_q;
        busy       = (state_q != IDLE);
        job_cnt    = cnt_q;
    end

endmodule

// File: tb/tb_tpu_job_sched.sv
// Directed self-checking bench for tpu_job_sched (CNT_WIDTH=2, TIMEOUT_CYCLES=16).
module tb_tpu_job_sched;

    logic       clk = 1'b0;
    logic       srstn;
    logic       req0_valid, req1_valid;
    logic       req0_ready, req1_ready;
    logic       tpu_start;
    logic       tpu_done;
    logic       rsp_valid, rsp_ready;
    logic       rsp_id, rsp_err;
    logic       busy;
    logic [1:0] job_cnt;

    int pass_cnt  = 0;
    int total_cnt = 0;

    tpu_job_sched #(.TIMEOUT_CYCLES(16), .CNT_WIDTH(2)) dut (
        .clk        (clk),
        .srstn      (srstn),
        .req0_valid (req0_valid),
        .req1_valid (req1_valid),
        .req0_ready (req0_ready),
        .req1_ready (req1_ready),
        .tpu_start  (tpu_start),
        .tpu_done   (tpu_done),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_err    (rsp_err),
        .busy       (busy),
        .job_cnt    (job_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        srstn = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0; tpu_done = 1'b0; rsp_ready = 1'b0;
        tick(); tick();
        srstn = 1'b1;
    endtask

    // One complete job for a lone requester, done after two RUN cycles.
    task automatic run_job(input bit id);
        if (id) req1_valid = 1'b1; else req0_valid = 1'b1;
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick(); tick();
        tpu_done = 1'b1;
        tick();
        tpu_done = 1'b0; rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        srstn = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0; tpu_done = 1'b1; rsp_ready = 1'b0;
        tick();
        total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else pass_cnt++;
        total_cnt++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); else pass_cnt++;
        total_cnt++; if (tpu_start !== 1'b0) $display("FAIL reset_tpu_start got %b exp 0", tpu_start); else pass_cnt++;
        total_cnt++; if (job_cnt !== 2'd0) $display("FAIL reset_job_cnt got %0d exp 0", job_cnt); else pass_cnt++;
        total_cnt++; if (rsp_err !== 1'b0) $display("FAIL reset_rsp_err got %b exp 0", rsp_err); else pass_cnt++;
        tpu_done = 1'b0; srstn = 1'b1;
        tick();
        total_cnt++; if (busy !== 1'b0) $display("FAIL post_reset_busy got %b exp 0", busy); else pass_cnt++;
        // First tie after reset goes to requester 0.
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        total_cnt++; if ({req1_ready, req0_ready} !== 2'b01) $display("FAIL first_tie got %b exp 01", {req1_ready, req0_ready}); else pass_cnt++;
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
        // Withdrawn requests must not move last_grant.
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        total_cnt++; if ({req1_ready, req0_ready} !== 2'b01) $display("FAIL tie_after_withdraw got %b exp 01", {req1_ready, req0_ready}); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL withdraw_busy got %b exp 0", busy); else pass_cnt++;
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
    endtask

    task automatic test_single();
        req0_valid = 1'b1;
        #1;
        total_cnt++; if (req0_ready !== 1'b1) $display("FAIL single_req0_ready got %b exp 1", req0_ready); else pass_cnt++;
        total_cnt++; if (req1_ready !== 1'b0) $display("FAIL single_req1_ready got %b exp 0", req1_ready); else pass_cnt++;
        tick();
        req0_valid = 1'b0;
        #1;
        total_cnt++; if (tpu_start !== 1'b1) $display("FAIL single_start got %b exp 1", tpu_start); else pass_cnt++;
        total_cnt++; if (busy !== 1'b1) $display("FAIL single_busy got %b exp 1", busy); else pass_cnt++;
        total_cnt++; if (req0_ready !== 1'b0) $display("FAIL single_ready_busy got %b exp 0", req0_ready); else pass_cnt++;
        tick();
        total_cnt++; if (tpu_start !== 1'b0) $display("FAIL single_start_once got %b exp 0", tpu_start); else pass_cnt++;
        tpu_done = 1'b1;
        tick();
        tpu_done = 1'b0;
        total_cnt++; if ({rsp_valid, rsp_id, rsp_err} !== 3'b100) $display("FAIL single_resp got %b exp 100", {rsp_valid, rsp_id, rsp_err}); else pass_cnt++;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        total_cnt++; if (job_cnt !== 2'd1) $display("FAIL single_job_cnt got %0d exp 1", job_cnt); else pass_cnt++;
        total_cnt++; if (rsp_valid !== 1'b0) $display("FAIL single_rsp_drop got %b exp 0", rsp_valid); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [2:0] exp_ids;
        bit         found;
        exp_ids = 3'b010;
        apply_reset();
        req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
        for (int j = 0; j < 3; j++) begin
            found = 1'b0;
            for (int k = 0; k < 4; k++) begin
                if (tpu_start === 1'b1) begin
                    found = 1'b1;
                    break;
                end
                tick();
            end
            total_cnt++; if (!found) $display("FAIL b2b_start_timeout job %0d got no start exp start", j); else pass_cnt++;
            if (j == 2) begin
                req0_valid = 1'b0; req1_valid = 1'b0;
            end
            repeat (10) tick();
            tpu_done = 1'b1;
            tick();
            tpu_done = 1'b0;
            total_cnt++; if (rsp_valid !== 1'b1) $display("FAIL b2b_rsp_valid job %0d got %b exp 1", j, rsp_valid); else pass_cnt++;
            total_cnt++; if (rsp_id !== exp_ids[j]) $display("FAIL b2b_rsp_id job %0d got %b exp %b", j, rsp_id, exp_ids[j]); else pass_cnt++;
            tick();
        end
        rsp_ready = 1'b0;
        total_cnt++; if (job_cnt !== 2'd3) $display("FAIL b2b_job_cnt got %0d exp 3", job_cnt); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL b2b_idle got %b exp 0", busy); else pass_cnt++;
    endtask

    task automatic test_done_ignored();
        tpu_done = 1'b1;
        tick();
        tpu_done = 1'b0;
        total_cnt++; if ({busy, rsp_valid} !== 2'b00) $display("FAIL done_in_idle got %b exp 00", {busy, rsp_valid}); else pass_cnt++;
        req1_valid = 1'b1;
        tick();
        req1_valid = 1'b0; tpu_done = 1'b1;
        #1;
        total_cnt++; if (tpu_start !== 1'b1) $display("FAIL done_start got %b exp 1", tpu_start); else pass_cnt++;
        tick();
        tpu_done = 1'b0;
        total_cnt++; if ({busy, rsp_valid} !== 2'b10) $display("FAIL done_in_start got %b exp 10", {busy, rsp_valid}); else pass_cnt++;
        repeat (3) tick();
        total_cnt++; if (rsp_valid !== 1'b0) $display("FAIL done_still_run got %b exp 0", rsp_valid); else pass_cnt++;
        tpu_done = 1'b1;
        tick();
        tpu_done = 1'b0;
        total_cnt++; if ({rsp_valid, rsp_id, rsp_err} !== 3'b110) $display("FAIL done_resp got %b exp 110", {rsp_valid, rsp_id, rsp_err}); else pass_cnt++;
        tpu_done = 1'b1;
        tick();
        tpu_done = 1'b0;
        total_cnt++; if ({rsp_valid, rsp_id, rsp_err} !== 3'b110) $display("FAIL done_in_resp got %b exp 110", {rsp_valid, rsp_id, rsp_err}); else pass_cnt++;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        total_cnt++; if (job_cnt !== 2'd0) $display("FAIL done_job_cnt got %0d exp 0", job_cnt); else pass_cnt++;
    endtask

    task automatic test_resp_hold();
        req0_valid = 1'b1;
        tick();
        req0_valid = 1'b0;
        tick(); tick();
        tpu_done = 1'b1;
        tick();
        tpu_done = 1'b0; req1_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            total_cnt++; if ({rsp_valid, rsp_id, rsp_err, req1_ready} !== 4'b1000) $display("FAIL hold_cycle%0d got %b exp 1000", i, {rsp_valid, rsp_id, rsp_err, req1_ready}); else pass_cnt++;
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        total_cnt++; if (req1_ready !== 1'b0) $display("FAIL hold_handshake_ready got %b exp 0", req1_ready); else pass_cnt++;
        tick();
        rsp_ready = 1'b0;
        #1;
        total_cnt++; if ({rsp_valid, req1_ready} !== 2'b01) $display("FAIL hold_after_rsp got %b exp 01", {rsp_valid, req1_ready}); else pass_cnt++;
        total_cnt++; if (job_cnt !== 2'd1) $display("FAIL hold_job_cnt got %0d exp 1", job_cnt); else pass_cnt++;
        tick();
        req1_valid = 1'b0;
        total_cnt++; if (tpu_start !== 1'b1) $display("FAIL hold_req1_start got %b exp 1", tpu_start); else pass_cnt++;
        tick();
        tpu_done = 1'b1;
        tick();
        tpu_done = 1'b0; rsp_ready = 1'b1;
        total_cnt++; if (rsp_id !== 1'b1) $display("FAIL hold_req1_id got %b exp 1", rsp_id); else pass_cnt++;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_watchdog();
`ifdef TPU_SCHED_WATCHDOG_EN
        req0_valid = 1'b1;
        tick();
        req0_valid = 1'b0;
        tick();
        repeat (15) tick();
        total_cnt++; if ({busy, rsp_valid} !== 2'b10) $display("FAIL wd_before_limit got %b exp 10", {busy, rsp_valid}); else pass_cnt++;
        tick();
        total_cnt++; if ({rsp_valid, rsp_id, rsp_err} !== 3'b101) $display("FAIL wd_timeout got %b exp 101", {rsp_valid, rsp_id, rsp_err}); else pass_cnt++;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        req1_valid = 1'b1;
        tick();
        req1_valid = 1'b0;
        tick();
        repeat (15) tick();
        tpu_done = 1'b1;
        tick();
        tpu_done = 1'b0;
        total_cnt++; if ({rsp_valid, rsp_id, rsp_err} !== 3'b110) $display("FAIL wd_done_wins got %b exp 110", {rsp_valid, rsp_id, rsp_err}); else pass_cnt++;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
`else
        req0_valid = 1'b1;
        tick();
        req0_valid = 1'b0;
        repeat (40) tick();
        total_cnt++; if ({busy, rsp_valid} !== 2'b10) $display("FAIL nowd_waits got %b exp 10", {busy, rsp_valid}); else pass_cnt++;
        tpu_done = 1'b1;
        tick();
        tpu_done = 1'b0;
        total_cnt++; if ({rsp_valid, rsp_id, rsp_err} !== 3'b100) $display("FAIL nowd_resp got %b exp 100", {rsp_valid, rsp_id, rsp_err}); else pass_cnt++;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
`endif
    endtask

    task automatic test_reset_mid_and_wrap();
        apply_reset();
        req0_valid = 1'b1;
        tick();
        req0_valid = 1'b0;
        tick(); tick();
        srstn = 1'b0;
        tick();
        srstn = 1'b1;
        tick();
        total_cnt++; if ({busy, rsp_valid, tpu_start} !== 3'b000) $display("FAIL mid_reset_state got %b exp 000", {busy, rsp_valid, tpu_start}); else pass_cnt++;
        total_cnt++; if (job_cnt !== 2'd0) $display("FAIL mid_reset_job_cnt got %0d exp 0", job_cnt); else pass_cnt++;
        tpu_done = 1'b1;
        tick();
        tpu_done = 1'b0;
        total_cnt++; if (rsp_valid !== 1'b0) $display("FAIL mid_reset_no_resp got %b exp 0", rsp_valid); else pass_cnt++;
        for (int i = 0; i < 5; i++) run_job(i[0]);
        total_cnt++; if (job_cnt !== 2'd1) $display("FAIL wrap_job_cnt got %0d exp 1", job_cnt); else pass_cnt++;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got no finish exp finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_done_ignored();
        test_resp_hold();
        test_watchdog();
        test_reset_mid_and_wrap();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
